// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: widths, ALUOp encodings,
// the EX slot record, the bubble constant and the WB snoop helper.
package id_ex_operand_stage_pkg;

  // Datapath, register-address and ALUOp widths
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OPW = 3;

  // Register 0 is hard-wired to zero and is never forwarded or snooped
  localparam logic [AW-1:0] REG_ZERO = '0;

  // ALUOp encodings understood by the downstream alu
  typedef enum logic [OPW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  // Everything the EX slot remembers about one instruction
  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] alu_op;
    logic [AW-1:0]  rs_addr;
    logic [AW-1:0]  rt_addr;
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
    logic [DW-1:0]  imm;
    logic           use_imm;
    logic [AW-1:0]  rd_addr;
    logic           reg_write;
  } ex_slot_t;

  // A bubble is simply the all-zero slot: not valid, no write-back
  localparam ex_slot_t EX_BUBBLE = '0;

  // Fold a same-cycle WB write into a register value about to be stored.
  // Address 0 is excluded so a stray WB to $zero can never corrupt it.
  function automatic logic [DW-1:0] wb_snoop(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] data,
    input logic          wb_we,
    input logic [AW-1:0] wb_addr,
    input logic [DW-1:0] wb_data
  );
    if (wb_we && (addr != REG_ZERO) && (wb_addr == addr)) begin
      return wb_data;
    end
    return data;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of every non-clock signal around the ID/EX operand stage.
// slave: the stage itself; master: whoever drives ID, MEM, WB and hazard control.
interface id_ex_operand_stage_if;
  import id_ex_operand_stage_pkg::*;

  // Hazard control
  logic           stall;
  logic           flush;

  // Decoded instruction from ID
  logic           id_valid;
  logic [OPW-1:0] id_alu_op;
  logic [AW-1:0]  id_rs_addr;
  logic [AW-1:0]  id_rt_addr;
  logic [DW-1:0]  id_rs_data;
  logic [DW-1:0]  id_rt_data;
  logic [DW-1:0]  id_imm;
  logic           id_use_imm;
  logic [AW-1:0]  id_rd_addr;
  logic           id_reg_write;

  // Forwarding sources from later stages
  logic           mem_reg_write;
  logic [AW-1:0]  mem_rd_addr;
  logic [DW-1:0]  mem_result;
  logic           wb_reg_write;
  logic [AW-1:0]  wb_rd_addr;
  logic [DW-1:0]  wb_result;

  // EX-side results
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  ex_rt_fwd;
  logic           ex_valid;
  logic [AW-1:0]  ex_rd_addr;
  logic           ex_reg_write;

  modport slave (
    input  stall, flush,
    input  id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
    input  id_imm, id_use_imm, id_rd_addr, id_reg_write,
    input  mem_reg_write, mem_rd_addr, mem_result,
    input  wb_reg_write, wb_rd_addr, wb_result,
    output alu_a, alu_b, alu_op, ex_rt_fwd, ex_valid, ex_rd_addr, ex_reg_write
  );

  modport master (
    output stall, flush,
    output id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
    output id_imm, id_use_imm, id_rd_addr, id_reg_write,
    output mem_reg_write, mem_rd_addr, mem_result,
    output wb_reg_write, wb_rd_addr, wb_result,
    input  alu_a, alu_b, alu_op, ex_rt_fwd, ex_valid, ex_rd_addr, ex_reg_write
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Combinational operand forwarding for one source register.
// Priority: $zero -> 0, then MEM result, then WB result, then the latched value.
// Kept standalone so the MEM-stage store-data path can reuse it.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_latched,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic [DW-1:0] o_value
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_we && (i_mem_addr == i_addr);
  assign w_wb_hit  = i_wb_we  && (i_wb_addr  == i_addr);

  // Pick the youngest producer of the register; $zero always reads 0
  always_comb begin
    o_value = i_latched;
    if (i_addr == REG_ZERO) begin
      o_value = '0;
    end else if (w_mem_hit) begin
      o_value = i_mem_data;
    end else if (w_wb_hit) begin
      o_value = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding.
// Holds on stall, bubbles on flush (flush wins), and snoops WB on every
// non-flush edge so a held or freshly captured operand is never stale.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  id_ex_operand_stage_if.slave bus
);

  // Index 0 is rs (ALU A), index 1 is rt (ALU B / store data)
  localparam int NSRC = 2;

  ex_slot_t r_slot;
  ex_slot_t w_slot_next;

  logic [AW-1:0] w_id_addr     [NSRC];
  logic [DW-1:0] w_id_data     [NSRC];
  logic [AW-1:0] w_src_addr    [NSRC];
  logic [DW-1:0] w_src_latched [NSRC];
  logic [DW-1:0] w_load_data   [NSRC];
  logic [DW-1:0] w_hold_data   [NSRC];
  logic [DW-1:0] w_src_fwd     [NSRC];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      if (gi == 0) begin : g_rs
        assign w_id_addr[gi]     = bus.id_rs_addr;
        assign w_id_data[gi]     = bus.id_rs_data;
        assign w_src_addr[gi]    = r_slot.rs_addr;
        assign w_src_latched[gi] = r_slot.rs_data;
      end else begin : g_rt
        assign w_id_addr[gi]     = bus.id_rt_addr;
        assign w_id_data[gi]     = bus.id_rt_data;
        assign w_src_addr[gi]    = r_slot.rt_addr;
        assign w_src_latched[gi] = r_slot.rt_data;
      end

      // Load path: covers the GRF read-during-write case
      assign w_load_data[gi] = wb_snoop(w_id_addr[gi], w_id_data[gi],
                                        bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);

      // Hold path: WB retiring during a long stall refreshes the held copy
      assign w_hold_data[gi] = wb_snoop(w_src_addr[gi], w_src_latched[gi],
                                        bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);

      id_ex_operand_stage_fwd_mux u_fwd_mux (
        .i_addr     (w_src_addr[gi]),
        .i_latched  (w_src_latched[gi]),
        .i_mem_we   (bus.mem_reg_write),
        .i_mem_addr (bus.mem_rd_addr),
        .i_mem_data (bus.mem_result),
        .i_wb_we    (bus.wb_reg_write),
        .i_wb_addr  (bus.wb_rd_addr),
        .i_wb_data  (bus.wb_result),
        .o_value    (w_src_fwd[gi])
      );
    end
  endgenerate

  // Next slot contents: flush beats stall beats load
  always_comb begin
    w_slot_next = r_slot;
    if (bus.flush) begin
      w_slot_next = EX_BUBBLE;
    end else if (bus.stall) begin
      w_slot_next.rs_data = w_hold_data[0];
      w_slot_next.rt_data = w_hold_data[1];
    end else begin
      w_slot_next.valid     = bus.id_valid;
      w_slot_next.alu_op    = bus.id_alu_op;
      w_slot_next.rs_addr   = bus.id_rs_addr;
      w_slot_next.rt_addr   = bus.id_rt_addr;
      w_slot_next.rs_data   = w_load_data[0];
      w_slot_next.rt_data   = w_load_data[1];
      w_slot_next.imm       = bus.id_imm;
      w_slot_next.use_imm   = bus.id_use_imm;
      w_slot_next.rd_addr   = bus.id_rd_addr;
      w_slot_next.reg_write = bus.id_reg_write & bus.id_valid;
    end
  end

  // EX slot register; reset clears it immediately, discarding any held instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= EX_BUBBLE;
    end else begin
      r_slot <= w_slot_next;
    end
  end

  assign bus.alu_a        = w_src_fwd[0];
  assign bus.alu_b        = r_slot.use_imm ? r_slot.imm : w_src_fwd[1];
  assign bus.ex_rt_fwd    = w_src_fwd[1];
  assign bus.alu_op       = r_slot.alu_op;
  assign bus.ex_valid     = r_slot.valid;
  assign bus.ex_rd_addr   = r_slot.rd_addr;
  assign bus.ex_reg_write = r_slot.reg_write & r_slot.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: each expected EX view is queued
// when its stimulus is set up and popped when the outputs are sampled.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic clk;
  logic reset;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [2:0]  op;
    logic        v;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] rt, input logic [2:0] op, input logic v,
                            input logic [4:0] rd, input logic rw);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.rt = rt; e.op = op; e.v = v; e.rd = rd; e.rw = rw;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
      return;
    end
    e = sb.pop_front();
    $display("txn %s: a=0x%08h b=0x%08h rt=0x%08h op=%0d v=%0b rd=%0d rw=%0b",
             e.tag, bus.alu_a, bus.alu_b, bus.ex_rt_fwd, bus.alu_op,
             bus.ex_valid, bus.ex_rd_addr, bus.ex_reg_write);
    check_val({e.tag, ".alu_a"},        bus.alu_a,                e.a);
    check_val({e.tag, ".alu_b"},        bus.alu_b,                e.b);
    check_val({e.tag, ".ex_rt_fwd"},    bus.ex_rt_fwd,            e.rt);
    check_val({e.tag, ".alu_op"},       32'(bus.alu_op),          32'(e.op));
    check_val({e.tag, ".ex_valid"},     32'(bus.ex_valid),        32'(e.v));
    check_val({e.tag, ".ex_rd_addr"},   32'(bus.ex_rd_addr),      32'(e.rd));
    check_val({e.tag, ".ex_reg_write"}, 32'(bus.ex_reg_write),    32'(e.rw));
  endtask

  task automatic drive_id(input logic v, input logic [2:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                          input logic rw);
    bus.id_valid     = v;
    bus.id_alu_op    = op;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_use_imm   = use_imm;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] ma, input logic [31:0] md,
                         input logic ww, input logic [4:0] wa, input logic [31:0] wd);
    bus.mem_reg_write = mw;
    bus.mem_rd_addr   = ma;
    bus.mem_result    = md;
    bus.wb_reg_write  = ww;
    bus.wb_rd_addr    = wa;
    bus.wb_result     = wd;
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    // Pass-through instruction is already on the ID side during reset
    drive_id(1, 3'd5, 5'd3, 5'd0, 32'hffff0000, 32'h0, 32'd4, 1'b1, 5'd7, 1'b1);
    #2;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    check_out();
    #1 reset = 1'b0;

    // Pass-through with immediate B
    step();
    expect_out("pass", 32'hffff0000, 32'd4, 0, 3'd5, 1, 5'd7, 1);
    check_out();

    // Forward priority on rs=8: MEM beats WB, then WB alone, then rt from MEM
    drive_id(1, 3'd2, 5'd8, 5'd10, 32'h5, 32'h77, 32'h0, 1'b0, 5'd11, 1'b1);
    step();
    set_fwd(1, 5'd8, 32'h11, 1, 5'd8, 32'h22);
    #1;
    expect_out("fwd_mem", 32'h11, 32'h77, 32'h77, 3'd2, 1, 5'd11, 1);
    check_out();
    set_fwd(0, 5'd8, 32'h11, 1, 5'd8, 32'h22);
    #1;
    expect_out("fwd_wb", 32'h22, 32'h77, 32'h77, 3'd2, 1, 5'd11, 1);
    check_out();
    set_fwd(1, 5'd10, 32'h99, 1, 5'd8, 32'h22);
    #1;
    expect_out("fwd_rt", 32'h22, 32'h99, 32'h99, 3'd2, 1, 5'd11, 1);
    check_out();

    // $zero is never forwarded even when MEM/WB claim to write it
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 3'd1, 5'd0, 5'd0, 32'h1234, 32'h55, 32'h0, 1'b0, 5'd0, 1'b1);
    step();
    set_fwd(1, 5'd0, 32'hdead, 1, 5'd0, 32'hbeef);
    #1;
    expect_out("zero", 0, 0, 0, 3'd1, 1, 5'd0, 1);
    check_out();

    // Load-edge snoop of a WB write to rs, on an invalid slot (reg_write gated)
    set_fwd(0, 0, 0, 1, 5'd12, 32'h333);
    drive_id(0, 3'd6, 5'd12, 5'd13, 32'h1, 32'h2, 32'h0, 1'b0, 5'd12, 1'b1);
    step();
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    expect_out("load_snoop", 32'h333, 32'h2, 32'h2, 3'd6, 0, 5'd12, 0);
    check_out();

    // Stall snoop on rt=9 across a three-edge hold
    drive_id(1, 3'd3, 5'd0, 5'd9, 32'h0, 32'h1, 32'h40, 1'b0, 5'd4, 1'b1);
    step();
    expect_out("stall_c0", 0, 32'h1, 32'h1, 3'd3, 1, 5'd4, 1);
    check_out();
    bus.stall = 1'b1;
    drive_id(1, 3'd7, 5'd2, 5'd2, 32'hff, 32'hff, 32'h0, 1'b0, 5'd1, 1'b0);
    step();
    expect_out("stall_c1", 0, 32'h1, 32'h1, 3'd3, 1, 5'd4, 1);
    check_out();
    step();
    set_fwd(0, 0, 0, 1, 5'd9, 32'habc);
    #1;
    expect_out("stall_c2", 0, 32'habc, 32'habc, 3'd3, 1, 5'd4, 1);
    check_out();
    step();
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    expect_out("stall_c3", 0, 32'habc, 32'habc, 3'd3, 1, 5'd4, 1);
    check_out();
    bus.stall = 1'b0;
    #1;
    expect_out("stall_rel", 0, 32'habc, 32'habc, 3'd3, 1, 5'd4, 1);
    check_out();

    // Flush and stall on the same edge: bubble
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    expect_out("flush", 0, 0, 0, 3'd0, 0, 5'd0, 0);
    check_out();
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Async reset between edges while stalled, then a normal load
    drive_id(1, 3'd2, 5'd5, 5'd0, 32'h5a, 32'h0, 32'h0, 1'b0, 5'd3, 1'b1);
    step();
    expect_out("pre_rst", 32'h5a, 0, 0, 3'd2, 1, 5'd3, 1);
    check_out();
    bus.stall = 1'b1;
    step();
    expect_out("pre_rst_hold", 32'h5a, 0, 0, 3'd2, 1, 5'd3, 1);
    check_out();
    #1 reset = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 3'd0, 0, 5'd0, 0);
    check_out();
    #1 reset = 1'b0;
    bus.stall = 1'b0;
    drive_id(1, 3'd4, 5'd6, 5'd7, 32'h66, 32'h77, 32'd9, 1'b1, 5'd2, 1'b1);
    step();
    expect_out("post_rst", 32'h66, 32'd9, 32'h77, 3'd4, 1, 5'd2, 1);
    check_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
